// File: rtl/agex_pkg.sv
// Shared definitions for the agex execute stage: op codes, FSM states and
// the multiply/divide classification used by the stage and its iterative unit.
package agex_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int SHAMT_W      = $clog2(DEFAULT_XLEN);
  localparam int OP_BITS      = 6;

  typedef enum logic [OP_BITS-1:0] {
    OP_ADD    = 6'h00,
    OP_SUB    = 6'h01,
    OP_AND    = 6'h02,
    OP_OR     = 6'h03,
    OP_XOR    = 6'h04,
    OP_SLL    = 6'h05,
    OP_SRL    = 6'h06,
    OP_SRA    = 6'h07,
    OP_SLT    = 6'h08,
    OP_SLTU   = 6'h09,
    OP_LUI    = 6'h0A,
    OP_AUIPC  = 6'h0B,
    OP_LOAD   = 6'h0C,
    OP_STORE  = 6'h0D,
    OP_JAL    = 6'h0E,
    OP_JALR   = 6'h0F,
    OP_BEQ    = 6'h10,
    OP_BNE    = 6'h11,
    OP_BLT    = 6'h12,
    OP_BGE    = 6'h13,
    OP_BLTU   = 6'h14,
    OP_BGEU   = 6'h15,
    OP_MUL    = 6'h20,
    OP_MULH   = 6'h21,
    OP_MULHSU = 6'h22,
    OP_MULHU  = 6'h23,
    OP_DIV    = 6'h24,
    OP_DIVU   = 6'h25,
    OP_REM    = 6'h26,
    OP_REMU   = 6'h27
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [OP_BITS-1:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/agex_md_stage_muldiv.sv
// Iterative RV-M unit: XLEN-step shift-add multiply or restoring divide on
// operand magnitudes, with sign correction and divide special cases at the end.
module muldiv_iter
  import agex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [OP_BITS-1:0] op_i,
  input  logic [XLEN-1:0]    a_i,
  input  logic [XLEN-1:0]    b_i,
  output logic               done_o,
  output logic [XLEN-1:0]    result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  logic            active_q, is_div_q, sel_hi_q, neg_q, neg_rem_q, divzero_q, ovf_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] a_q, mc_q, hi_q, lo_q;

  logic            a_neg, b_neg, start_div;
  logic [XLEN-1:0] a_mag, b_mag, hi_d, lo_d;
  logic [XLEN:0]   mul_sum, div_sh;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;

  always_comb begin
    a_neg     = (op_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a_i[XLEN-1];
    b_neg     = (op_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && b_i[XLEN-1];
    a_mag     = a_neg ? -a_i : a_i;
    b_mag     = b_neg ? -b_i : b_i;
    start_div = op_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  end

  // hi/lo hold the running product for multiply, remainder/quotient for divide
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_ge   = div_sh >= {1'b0, mc_q};
    div_diff = div_sh[XLEN-1:0] - mc_q;
    if (is_div_q) begin
      hi_d = div_ge ? div_diff : div_sh[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q  <= 1'b0;
      is_div_q  <= 1'b0;
      sel_hi_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      divzero_q <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      a_q       <= '0;
      mc_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (start_i) begin
      active_q  <= 1'b1;
      is_div_q  <= start_div;
      sel_hi_q  <= op_i inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
      neg_q     <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      divzero_q <= start_div && (b_i == '0);
      ovf_q     <= (op_i inside {OP_DIV, OP_REM}) && (a_i == MIN_VAL) && (b_i == '1);
      cnt_q     <= '0;
      a_q       <= a_i;
      mc_q      <= b_mag;
      hi_q      <= '0;
      lo_q      <= a_mag;
    end else if (active_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) active_q <= 1'b0;
    end
  end

  assign done_o = active_q && (cnt_q == LAST);

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -lo_q : lo_q;
    rem    = neg_rem_q ? -hi_q : hi_q;
    if (divzero_q) begin
      quo = '1;
      rem = a_q;
    end else if (ovf_q) begin
      quo = MIN_VAL;
      rem = '0;
    end
    if (is_div_q) result_o = sel_hi_q ? rem : quo;
    else          result_o = sel_hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
  end

endmodule

// File: rtl/agex_md_stage.sv
// Execute stage: single-cycle ALU/branch/jump, iterative mul/div, valid/ready
// handshakes on both sides and a registered one-cycle redirect to fetch.
module agex_md_stage
  import agex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 6,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic            in_use_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_wr_reg,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [OP_W-1:0] out_op,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_rs2,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wr_reg,
  output logic            busy,
  output logic            br_valid,
  output logic [XLEN-1:0] br_target
);

  localparam int SHW = $clog2(XLEN);

  state_e          state_q;
  logic            out_valid_q, out_wr_q, br_valid_q, md_wr_q;
  logic [XLEN-1:0] out_pc_q, out_result_q, out_rs2_q, br_target_q, md_pc_q, md_rs2_q;
  logic [OP_W-1:0] out_op_q, md_op_q;
  logic [RD_W-1:0] out_rd_q, md_rd_q;

  logic            accept, md_start, md_done, known, redirect;
  logic [XLEN-1:0] opb, alu_res, target, jalr_sum, md_result;
  logic [SHW-1:0]  shamt;

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign md_start = accept && is_muldiv(in_op);

  always_comb begin
    opb      = in_use_imm ? in_imm : in_rs2;
    shamt    = opb[SHW-1:0];
    jalr_sum = in_rs1 + in_imm;
    alu_res  = '0;
    known    = 1'b1;
    redirect = 1'b0;
    target   = in_pc + in_imm;
    case (in_op)
      OP_ADD:   alu_res = in_rs1 + opb;
      OP_SUB:   alu_res = in_rs1 - opb;
      OP_AND:   alu_res = in_rs1 & opb;
      OP_OR:    alu_res = in_rs1 | opb;
      OP_XOR:   alu_res = in_rs1 ^ opb;
      OP_SLL:   alu_res = in_rs1 << shamt;
      OP_SRL:   alu_res = in_rs1 >> shamt;
      OP_SRA:   alu_res = $signed(in_rs1) >>> shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(in_rs1) < $signed(opb)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, in_rs1 < opb};
      OP_LUI:   alu_res = in_imm;
      OP_AUIPC: alu_res = in_pc + in_imm;
      OP_LOAD, OP_STORE: alu_res = jalr_sum;
      OP_JAL: begin
        alu_res  = in_pc + XLEN'(4);
        redirect = 1'b1;
      end
      OP_JALR: begin
        alu_res  = in_pc + XLEN'(4);
        redirect = 1'b1;
        target   = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
      end
      OP_BEQ:  redirect = in_rs1 == in_rs2;
      OP_BNE:  redirect = in_rs1 != in_rs2;
      OP_BLT:  redirect = $signed(in_rs1) < $signed(in_rs2);
      OP_BGE:  redirect = $signed(in_rs1) >= $signed(in_rs2);
      OP_BLTU: redirect = in_rs1 < in_rs2;
      OP_BGEU: redirect = in_rs1 >= in_rs2;
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_res = '0;
      default: known = 1'b0;
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (md_start),
    .op_i     (in_op),
    .a_i      (in_rs1),
    .b_i      (opb),
    .done_o   (md_done),
    .result_o (md_result)
  );

  // Latch contents only change when the latch is free, so MEM sees stable data under back-pressure
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_op_q     <= '0;
      out_result_q <= '0;
      out_rs2_q    <= '0;
      out_rd_q     <= '0;
      out_wr_q     <= 1'b0;
      br_valid_q   <= 1'b0;
      br_target_q  <= '0;
      md_pc_q      <= '0;
      md_op_q      <= '0;
      md_rs2_q     <= '0;
      md_rd_q      <= '0;
      md_wr_q      <= 1'b0;
    end else begin
      br_valid_q <= accept && known && redirect;
      if (accept && known && redirect) br_target_q <= target;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (md_start) begin
            state_q  <= ST_BUSY;
            md_pc_q  <= in_pc;
            md_op_q  <= in_op;
            md_rs2_q <= in_rs2;
            md_rd_q  <= in_rd;
            md_wr_q  <= in_wr_reg;
          end else if (accept) begin
            out_valid_q  <= 1'b1;
            out_pc_q     <= in_pc;
            out_op_q     <= in_op;
            out_result_q <= alu_res;
            out_rs2_q    <= in_rs2;
            out_rd_q     <= in_rd;
            out_wr_q     <= in_wr_reg && known;
          end
        end
        ST_BUSY: if (md_done) state_q <= ST_DONE;
        ST_DONE: begin
          if (!out_valid_q || out_ready) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b1;
            out_pc_q     <= md_pc_q;
            out_op_q     <= md_op_q;
            out_result_q <= md_result;
            out_rs2_q    <= md_rs2_q;
            out_rd_q     <= md_rd_q;
            out_wr_q     <= md_wr_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_op     = out_op_q;
  assign out_result = out_result_q;
  assign out_rs2    = out_rs2_q;
  assign out_rd     = out_rd_q;
  assign out_wr_reg = out_wr_q;
  assign busy       = (state_q != ST_IDLE);
  assign br_valid   = br_valid_q;
  assign br_target  = br_target_q;

endmodule

// File: tb/tb_agex_md_stage.sv
// Directed bench for agex_md_stage (XLEN=32): ALU, branches, mul/div special
// cases with exact latency, output back-pressure and reset during a divide.
module tb_agex_md_stage;
  import agex_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_use_imm, in_wr_reg;
  logic [5:0]  in_op;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_wr_reg, busy, br_valid;
  logic [31:0] out_pc, out_result, out_rs2, br_target;
  logic [5:0]  out_op;
  logic [4:0]  out_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  agex_md_stage #(.XLEN(32), .OP_W(6), .RD_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_use_imm(in_use_imm),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_rd(in_rd), .in_wr_reg(in_wr_reg),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_result(out_result), .out_rs2(out_rs2), .out_rd(out_rd), .out_wr_reg(out_wr_reg),
    .busy(busy), .br_valid(br_valid), .br_target(br_target)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic use_imm,
                               input logic [31:0] pc, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] imm,
                               input logic [4:0] rd, input logic wr);
    in_valid   = 1'b1;
    in_op      = op;
    in_use_imm = use_imm;
    in_pc      = pc;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_imm     = imm;
    in_rd      = rd;
    in_wr_reg  = wr;
  endtask

  task automatic runAlu(input string tag, input logic [5:0] op, input logic use_imm,
                        input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [31:0] expected);
    applyStimulus(op, use_imm, pc, rs1, rs2, imm, 5'd1, 1'b1);
    checkOutput({tag, " in_ready"}, in_ready, 1);
    tick();
    checkOutput({tag, " out_valid"}, out_valid, 1);
    checkOutput({tag, " result"}, out_result, expected);
  endtask

  task automatic waitResult(input string tag);
    int   cycles;
    logic ready_seen;
    cycles     = 0;
    ready_seen = 1'b0;
    while (!out_valid && cycles < 40) begin
      if (in_ready) ready_seen = 1'b1;
      tick();
      cycles++;
    end
    checkOutput({tag, " latency"}, cycles, 33);
    checkOutput({tag, " in_ready low"}, ready_seen, 0);
  endtask

  task automatic runMulDiv(input string tag, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expected);
    applyStimulus(op, 1'b0, 32'h500, a, b, 32'h0, 5'd7, 1'b1);
    checkOutput({tag, " accept ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    checkOutput({tag, " busy"}, busy, 1);
    waitResult(tag);
    checkOutput({tag, " result"}, out_result, expected);
    checkOutput({tag, " rd"}, out_rd, 5'd7);
  endtask

  initial begin
    reset     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(6'h0, 1'b0, '0, '0, '0, '0, '0, 1'b0);
    in_valid  = 1'b0;
    tick();
    tick();
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset br_valid", br_valid, 0);
    checkOutput("reset out_result", out_result, 0);
    checkOutput("reset in_ready", in_ready, 1);
    reset = 1'b1;
    tick();

    // Single-cycle ALU ops, issued back to back
    runAlu("ADD", OP_ADD, 1'b0, 32'h10, 32'd7, 32'hFFFF_FFFD, 32'h0, 32'd4);
    checkOutput("ADD pc", out_pc, 32'h10);
    checkOutput("ADD wr_reg", out_wr_reg, 1);
    checkOutput("ADD br_valid", br_valid, 0);
    runAlu("SUB", OP_SUB, 1'b0, 32'h14, 32'd10, 32'd3, 32'h0, 32'd7);
    runAlu("SLL imm", OP_SLL, 1'b1, 32'h18, 32'd1, 32'h0, 32'h24, 32'h10);
    runAlu("SRA", OP_SRA, 1'b0, 32'h1C, 32'h8000_0000, 32'd4, 32'h0, 32'hF800_0000);
    runAlu("SLT", OP_SLT, 1'b0, 32'h20, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd1);
    runAlu("SLTU", OP_SLTU, 1'b0, 32'h24, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd0);
    runAlu("AUIPC", OP_AUIPC, 1'b1, 32'h100, 32'h0, 32'h0, 32'h2000, 32'h2100);
    runAlu("STORE", OP_STORE, 1'b1, 32'h28, 32'h1000, 32'hDEAD, 32'h10, 32'h1010);
    checkOutput("STORE data", out_rs2, 32'hDEAD);

    // Branch resolution and redirect pulse
    runAlu("BLT", OP_BLT, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h0);
    checkOutput("BLT br_valid", br_valid, 1);
    checkOutput("BLT br_target", br_target, 32'h120);
    in_valid = 1'b0;
    tick();
    checkOutput("BLT pulse width", br_valid, 0);
    runAlu("BLTU", OP_BLTU, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h0);
    checkOutput("BLTU br_valid", br_valid, 0);
    runAlu("JALR", OP_JALR, 1'b1, 32'h400, 32'h203, 32'h0, 32'h0, 32'h404);
    checkOutput("JALR br_valid", br_valid, 1);
    checkOutput("JALR br_target", br_target, 32'h202);
    runAlu("UNKNOWN", 6'h3F, 1'b0, 32'h500, 32'h55, 32'h66, 32'h77, 32'h0);
    checkOutput("UNKNOWN wr_reg", out_wr_reg, 0);
    checkOutput("UNKNOWN br_valid", br_valid, 0);
    in_valid = 1'b0;
    tick();

    // Multiply / divide including special cases
    runMulDiv("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    runMulDiv("REM by0", OP_REM, 32'h1234_5678, 32'h0, 32'h1234_5678);
    runMulDiv("DIVU by0", OP_DIVU, 32'd100, 32'h0, 32'hFFFF_FFFF);
    runMulDiv("DIV neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    runMulDiv("REM neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    runMulDiv("MULH", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    runMulDiv("MULHU", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runMulDiv("MUL", OP_MUL, 32'h0001_2345, 32'h100, 32'h0123_4500);
    tick();

    // Back-pressure: result held while MEM stalls, pending op blocked
    out_ready = 1'b0;
    applyStimulus(OP_MUL, 1'b0, 32'h600, 32'd6, 32'd7, 32'h0, 5'd9, 1'b1);
    tick();
    in_valid = 1'b0;
    waitResult("BP MUL");
    checkOutput("BP MUL result", out_result, 32'd42);
    applyStimulus(OP_ADD, 1'b0, 32'h604, 32'd1, 32'd2, 32'h0, 5'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("BP hold valid", out_valid, 1);
      checkOutput("BP hold result", out_result, 32'd42);
      checkOutput("BP hold op", out_op, OP_MUL);
      checkOutput("BP hold in_ready", in_ready, 0);
      checkOutput("BP hold busy", busy, 0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("BP release in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    checkOutput("BP next valid", out_valid, 1);
    checkOutput("BP next result", out_result, 32'd3);
    tick();

    // Asynchronous reset in the middle of a divide
    applyStimulus(OP_DIV, 1'b0, 32'h700, 32'd1000, 32'd7, 32'h0, 5'd2, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    checkOutput("RST pre busy", busy, 1);
    reset = 1'b0;
    #1;
    checkOutput("RST out_valid", out_valid, 0);
    checkOutput("RST busy", busy, 0);
    checkOutput("RST br_valid", br_valid, 0);
    checkOutput("RST out_result", out_result, 0);
    tick();
    reset = 1'b1;
    tick();
    runAlu("RST ADD", OP_ADD, 1'b0, 32'h800, 32'd2, 32'd3, 32'h0, 32'd5);
    in_valid = 1'b0;
    repeat (40) tick();
    checkOutput("RST no stale result", out_valid, 0);
    checkOutput("RST idle busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/agex_md_stage.md
Name: agex_md_stage

Overview:
- Parametrised execute stage for the RV32/RV64 in-order pipeline. It sits between the DE latch and the MEM stage.
- Executes single-cycle ALU, branch and jump ops, plus RV-M multiply/divide through an iterative multi-cycle unit.
- Uses valid/ready handshakes on both sides in place of the fixed-latch scheme, so it can stall upstream and absorb MEM back-pressure.
- Resolves branches and emits a registered redirect to FE.

Parameters:
- XLEN, 32: datapath width; legal values are 32 and 64.
- OP_W, 6: width of the internal op code.
- RD_W, 5: destination register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  DE presents an op.
- in_ready  out  1  stage accepts the op on this edge.
- in_op  in  OP_W  op code (package enum).
- in_use_imm  in  1  operand B = in_imm instead of in_rs2.
- in_pc  in  XLEN  instruction PC.
- in_rs1  in  XLEN  rs1 value.
- in_rs2  in  XLEN  rs2 value.
- in_imm  in  XLEN  sign-extended immediate.
- in_rd  in  RD_W  destination register.
- in_wr_reg  in  1  op writes rd.
- out_valid  out  1  result latch holds an op.
- out_ready  in  1  MEM accepts the latch.
- out_pc  out  XLEN  forwarded PC.
- out_op  out  OP_W  forwarded op.
- out_result  out  XLEN  ALU/link/mul/div result, or memory address.
- out_rs2  out  XLEN  store data.
- out_rd  out  RD_W  forwarded destination.
- out_wr_reg  out  1  forwarded write enable.
- busy  out  1  multi-cycle op in flight (to DE hazard logic).
- br_valid  out  1  one-cycle redirect pulse to FE.
- br_target  out  XLEN  redirect PC.

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE; out_valid=0; br_valid=0; busy=0; all data outputs=0. An in-flight mul/div is discarded.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - A transfer occurs on a clock edge where in_valid && in_ready.
  - While out_valid && !out_ready, all out_* signals are held stable.
- Operand B = in_use_imm ? in_imm : in_rs2.
- Shifts use B[log2(XLEN)-1:0]; SRA is arithmetic.
- SLT/SLTU: result = (rs1 < B) signed/unsigned, zero-extended.
- LUI: result = imm. AUIPC: result = pc+imm.
- Loads/stores: result = rs1+imm.
- JAL/JALR: result = pc+4.
- Branch conditions: BEQ, BNE, BLT, BGE (signed); BLTU, BGEU (unsigned).
- Single-cycle ops: the op accepted at edge N is in the latch with out_valid=1 after edge N.
- Redirect:
  - A taken branch, JAL or JALR asserts br_valid for exactly one cycle after the accept edge, independent of out_ready.
  - br_target = pc+imm for branches and JAL.
  - For JALR, br_target = (rs1+imm) with bit 0 cleared.
  - A not-taken branch gives br_valid=0.
- FSM:
  - IDLE to BUSY on acceptance of MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU. Operands are captured; busy=1.
  - BUSY runs XLEN iterations (shift-add multiply or restoring divide; signs are handled by pre/post negation).
  - BUSY to DONE when the counter reaches XLEN-1.
  - DONE loads the latch when !out_valid || out_ready, then returns to IDLE (busy=0).
  - Latency: accept at edge N gives out_valid after edge N+XLEN+1 when the latch is free. DONE waits otherwise.
- Special cases use the same fixed latency:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
- MULH variants return the upper XLEN bits of the 2*XLEN product; MUL returns the lower XLEN bits.
- Unknown op: result=0, no redirect, out_wr_reg forced to 0.

Decomposition:
- Shared package agex_pkg holds:
  - The op enum (ALU, branch, jump, load/store, M ops).
  - The FSM state encoding IDLE/BUSY/DONE.
  - An is_muldiv() classification function.
  - The constant SHAMT_W = $clog2(XLEN).
- Sub-module muldiv_iter (parametrised by XLEN):
  - start/op/a/b inputs; done/result outputs.
  - Contains the iteration counter and sign fix-up.
  - The top level holds the handshake FSM, ALU, branch unit and output latch.

Test Plan (XLEN=32):
- Single-cycle op: ADD rs1=7, rs2=0xFFFFFFFD with out_ready=1 -> out_valid next cycle, out_result=4; in_ready stays 1 for back-to-back ops.
- Branches:
  - BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> br_valid pulse, br_target=0x120.
  - BLTU with the same operands -> br_valid=0.
  - JALR rs1=0x203, imm=0 -> br_target=0x202, result=pc+4.
- Divide edge cases:
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM x/0 -> x.
  - DIVU 100/0 -> 0xFFFFFFFF.
  - In each case out_valid arrives exactly 33 cycles after accept and in_ready=0 throughout.
- Multiply: MULH 0xFFFFFFFF * 0xFFFFFFFF -> 0; MULHU with the same operands -> 0xFFFFFFFE.
- Back-pressure: hold out_ready=0 with a MUL finishing -> DONE waits, out_* stable, in_ready=0; release -> latch loads, FSM returns to IDLE.
- Reset mid-operation: drop reset low in cycle 10 of a DIV -> out_valid=0, busy=0, br_valid=0 immediately; after release, a new ADD completes normally.
